// File: rtl/usb_ep_buf_arbiter.sv
// -----------------------------------------------------------------------------
// usb_ep_buf_arbiter
//
// Shares one single-port endpoint packet RAM between the USB SIE and the J1
// CPU. The SIE has fixed priority. The CPU still gets a bounded wait: after
// STARVE consecutive denied cycles it wins the next contention. Each of the
// NUM_EP buffers belongs to one side at a time. An access to a buffer the
// requester does not own is still granted, but the RAM is left idle and the
// requester gets an err pulse one cycle later.
//
// Request handshake (applies to both the sie_* and the cpu_* port groups):
//   req is the "valid" and gnt is the "ready". The requester raises req with
//   we/addr/wdata and keeps all of them stable until it sees gnt in the same
//   cycle. The transfer completes in the cycle where req && gnt. req may be
//   dropped only after that cycle. gnt is combinational in the request cycle,
//   and at most one gnt is high in any cycle. A permitted read returns data
//   one cycle later: <side>_rvalid is high and rdata holds the data. A blocked
//   access produces <side>_err for one cycle instead, and never produces rvalid.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   sie_req/we/addr/wdata SIE request          sie_gnt/rvalid/err  SIE response
//   cpu_req/we/addr/wdata CPU request          cpu_gnt/rvalid/err  CPU response
//   sie_give / cpu_give   one-cycle pulses that hand buffers to the other side
//   rdata                 shared read data; qualify it with *_rvalid
//   owner                 bit i = 1 means the SIE owns buffer i
//   ram_en/we/addr/wdata  RAM macro control
//   ram_rdata             RAM macro read data, 1-cycle latency
// -----------------------------------------------------------------------------
module usb_ep_buf_arbiter #(
   parameter int AW         = 9,
   parameter int EPW        = 2,
   parameter int STARVE     = 4,
   localparam int NUM_EP    = 2 ** EPW
) (
   input  logic              clk,
   input  logic              reset,
   // SIE side
   input  logic              sie_req,
   input  logic              sie_we,
   input  logic [AW-1:0]     sie_addr,
   input  logic [7:0]        sie_wdata,
   output logic              sie_gnt,
   output logic              sie_rvalid,
   output logic              sie_err,
   input  logic [NUM_EP-1:0] sie_give,
   // CPU side
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AW-1:0]     cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic              cpu_err,
   input  logic [NUM_EP-1:0] cpu_give,
   // shared
   output logic [7:0]        rdata,
   output logic [NUM_EP-1:0] owner,
   // RAM macro
   output logic              ram_en,
   output logic              ram_we,
   output logic [AW-1:0]     ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   localparam int SCW = $clog2(STARVE + 1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE);

   logic [SCW-1:0] starve_cnt;
   logic           cpu_wins;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [7:0]     sel_wdata;
   logic [EPW-1:0] sel_ep;
   logic           permit;

   // The CPU wins when it is alone, or when it has waited long enough that
   // it overrides the SIE priority.
   assign cpu_wins = cpu_req && (!sie_req || (starve_cnt >= STARVE_MAX));

   always_comb begin
      sie_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_ep    = '0;
      permit    = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      // Grants are held off while reset is asserted. This keeps the RAM idle
      // during reset.
      cpu_gnt = reset && cpu_wins;
      sie_gnt = reset && sie_req && !cpu_wins;

      if (sie_gnt) begin
         sel_we    = sie_we;
         sel_addr  = sie_addr;
         sel_wdata = sie_wdata;
      end else if (cpu_gnt) begin
         sel_we    = cpu_we;
         sel_addr  = cpu_addr;
         sel_wdata = cpu_wdata;
      end

      // Ownership is checked against the registered owner vector, which is
      // the value before any give in this cycle.
      sel_ep = sel_addr[AW-1 -: EPW];
      if (sie_gnt)      permit = owner[sel_ep];
      else if (cpu_gnt) permit = !owner[sel_ep];

      if (permit) begin
         ram_en    = 1'b1;
         ram_we    = sel_we;
         ram_addr  = sel_addr;
         ram_wdata = sel_wdata;
      end
   end

   // The RAM has a fixed 1-cycle latency, so its output lines up with the
   // registered rvalid strobes without extra staging.
   assign rdata = ram_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= '0;
         starve_cnt <= '0;
         sie_rvalid <= 1'b0;
         sie_err    <= 1'b0;
         cpu_rvalid <= 1'b0;
         cpu_err    <= 1'b0;
      end else begin
         // Only the current owner's give takes effect. When both sides give
         // the same bit, the non-owner's pulse is masked out.
         owner <= (owner & ~sie_give) | (~owner & cpu_give);

         if (cpu_req && !cpu_gnt) begin
            if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + SCW'(1);
         end else begin
            starve_cnt <= '0;
         end

         sie_rvalid <= sie_gnt && permit && !sie_we;
         sie_err    <= sie_gnt && !permit;
         cpu_rvalid <= cpu_gnt && permit && !cpu_we;
         cpu_err    <= cpu_gnt && !permit;
      end
   end

endmodule

// File: tb/tb_usb_ep_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_ep_buf_arbiter
//
// Directed bench for usb_ep_buf_arbiter. It includes a behavioural
// 1-cycle-latency RAM. The expected read data is queued as {is_sie, byte}
// when a read request is driven. The item is popped and compared when either
// rvalid rises.
// -----------------------------------------------------------------------------
module tb_usb_ep_buf_arbiter;

   localparam int AW     = 9;
   localparam int EPW    = 2;
   localparam int STARVE = 4;
   localparam int NUM_EP = 2 ** EPW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic              sie_req = 1'b0, sie_we = 1'b0;
   logic [AW-1:0]     sie_addr = '0;
   logic [7:0]        sie_wdata = '0;
   logic              sie_gnt, sie_rvalid, sie_err;
   logic [NUM_EP-1:0] sie_give = '0;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0]     cpu_addr = '0;
   logic [7:0]        cpu_wdata = '0;
   logic              cpu_gnt, cpu_rvalid, cpu_err;
   logic [NUM_EP-1:0] cpu_give = '0;
   logic [7:0]        rdata;
   logic [NUM_EP-1:0] owner;
   logic              ram_en, ram_we;
   logic [AW-1:0]     ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata = '0;

   usb_ep_buf_arbiter #(.AW(AW), .EPW(EPW), .STARVE(STARVE)) dut (
      .clk(clk), .reset(reset),
      .sie_req(sie_req), .sie_we(sie_we), .sie_addr(sie_addr), .sie_wdata(sie_wdata),
      .sie_gnt(sie_gnt), .sie_rvalid(sie_rvalid), .sie_err(sie_err), .sie_give(sie_give),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err), .cpu_give(cpu_give),
      .rdata(rdata), .owner(owner),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // ---------------- RAM model ----------------
   logic [7:0] mem [0:(2**AW)-1];
   initial for (int i = 0; i < 2 ** AW; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];
   int cmp_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sie_rvalid || cpu_rvalid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", 32'(sie_rvalid), 32'd2);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("read_return", {23'd0, sie_rvalid, rdata}, {23'd0, e});
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cpu(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic drive_sie(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      sie_req = 1'b1; sie_we = we; sie_addr = a; sie_wdata = d;
   endtask

   task automatic idle();
      cpu_req = 1'b0; sie_req = 1'b0; cpu_give = '0; sie_give = '0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset state: a CPU request during reset must not be granted.
      drive_cpu(1'b1, 9'h005, 8'hFF);
      repeat (2) next_cycle();
      @(negedge clk);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
      check("rst_ram_en", 32'(ram_en), 32'h0);
      check("rst_valid_err", {28'd0, sie_rvalid, sie_err, cpu_rvalid, cpu_err}, 32'h0);
      next_cycle();
      idle();
      reset = 1'b1;
      next_cycle();

      // CPU write 0xA5 to 0x005, then read it back.
      drive_cpu(1'b1, 9'h005, 8'hA5);
      @(negedge clk);
      check("t1_wr_gnt", {30'd0, sie_gnt, cpu_gnt}, 32'h1);
      check("t1_wr_ram", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 9'h005, 8'hA5});
      next_cycle();
      drive_cpu(1'b0, 9'h005, 8'h00);
      exp_q.push_back({1'b0, 8'hA5});
      @(negedge clk);
      check("t1_wr_err", 32'(cpu_err), 32'h0);
      check("t1_rd_gnt", 32'(cpu_gnt), 32'h1);
      check("t1_rd_ram", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 9'h005});
      next_cycle();
      idle();
      @(negedge clk);
      check("t1_rd_rvalid", {cpu_rvalid, cpu_err}, 32'h2);
      next_cycle();

      // The SIE reads a CPU-owned buffer: it is granted but blocked.
      drive_sie(1'b0, 9'h005, 8'h00);
      @(negedge clk);
      check("t2_blk_gnt", {30'd0, sie_gnt, cpu_gnt}, 32'h2);
      check("t2_blk_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 32'h0);
      next_cycle();
      idle();
      @(negedge clk);
      check("t2_blk_err", {sie_err, sie_rvalid}, 32'h2);
      next_cycle();
      cpu_give = 4'b0001;
      @(negedge clk);
      check("t2_err_pulse", 32'(sie_err), 32'h0);
      next_cycle();
      idle();
      @(negedge clk);
      check("t2_owner", 32'(owner), 32'h1);
      next_cycle();
      drive_sie(1'b0, 9'h005, 8'h00);
      exp_q.push_back({1'b1, 8'hA5});
      @(negedge clk);
      check("t2_ok_ram_en", 32'(ram_en), 32'h1);
      next_cycle();
      idle();
      @(negedge clk);
      check("t2_ok_rvalid", {sie_rvalid, sie_err}, 32'h2);
      next_cycle();

      // SIE write into its own buffer 0. After that, a CPU write to buffer 0
      // is blocked.
      drive_sie(1'b1, 9'h010, 8'h3C);
      @(negedge clk);
      check("t3_sie_wr_ram", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 9'h010, 8'h3C});
      next_cycle();
      idle();
      drive_cpu(1'b1, 9'h011, 8'h99);
      @(negedge clk);
      check("t3_sie_wr_err", 32'(sie_err), 32'h0);
      check("t3_cpu_blk", {cpu_gnt, ram_en, ram_we}, 32'h4);
      next_cycle();
      idle();
      @(negedge clk);
      check("t3_cpu_err", {cpu_err, cpu_rvalid}, 32'h2);
      next_cycle();

      // Contention: the SIE writes to buffer 0 and the CPU writes to buffer 1.
      drive_sie(1'b1, 9'h020, 8'h11);
      drive_cpu(1'b1, 9'h080, 8'h22);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("t4_gnt_c%0d", i), {30'd0, sie_gnt, cpu_gnt},
               (i == 4 || i == 9) ? 32'h1 : 32'h2);
         check($sformatf("t4_ram_en_c%0d", i), 32'(ram_en), 32'h1);
         next_cycle();
      end
      idle();
      next_cycle();

      // CPU writes 0x5A to buffer 2. Then both sides give buffer 2 together
      // with a CPU read of it. The give to buffer 1 comes from a non-owner.
      drive_cpu(1'b1, 9'h100, 8'h5A);
      next_cycle();
      idle();
      drive_cpu(1'b0, 9'h100, 8'h00);
      cpu_give = 4'b0100;
      sie_give = 4'b0110;
      exp_q.push_back({1'b0, 8'h5A});
      @(negedge clk);
      check("t5_pre_give_rd", {cpu_gnt, ram_en}, 32'h3);
      next_cycle();
      idle();
      @(negedge clk);
      check("t5_owner", 32'(owner), 32'h5);
      check("t5_rd_ok", {cpu_rvalid, cpu_err}, 32'h2);
      next_cycle();

      // Reset asserted during a granted SIE read.
      drive_sie(1'b0, 9'h010, 8'h00);
      @(negedge clk);
      check("t6_gnt", 32'(sie_gnt), 32'h1);
      #1 reset = 1'b0;
      #1 idle();
      @(posedge clk);
      #1;
      check("t6_rst_rvalid", {sie_rvalid, sie_err}, 32'h0);
      check("t6_rst_owner", 32'(owner), 32'h0);
      next_cycle();
      reset = 1'b1;
      drive_cpu(1'b0, 9'h005, 8'h00);
      exp_q.push_back({1'b0, 8'hA5});
      @(negedge clk);
      check("t6_post_gnt", {cpu_gnt, ram_en}, 32'h3);
      next_cycle();
      idle();
      @(negedge clk);
      check("t6_post_rvalid", 32'(cpu_rvalid), 32'h1);
      next_cycle();
      next_cycle();

      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
